// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, types and round/schedule helper functions.
// Used by the nonce core and by the miner top that instantiates the lanes.
package sha256_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        FINAL   = 2'd2
    } state_t;

    localparam word_t K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // IV[0] (H0) sits in the least significant word.
    localparam logic [7:0][31:0] IV = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

    function automatic word_t rightrotate(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return rightrotate(x, 2) ^ rightrotate(x, 13) ^ rightrotate(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rightrotate(x, 6) ^ rightrotate(x, 11) ^ rightrotate(x, 25);
    endfunction

    function automatic word_t small_sigma0(input word_t x);
        return rightrotate(x, 7) ^ rightrotate(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return rightrotate(x, 17) ^ rightrotate(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t ch(input word_t e, input word_t f, input word_t g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic word_t maj(input word_t a, input word_t b, input word_t c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    // Next schedule word from the 16-word rolling window.
    function automatic word_t sched_word(input word_t w14, input word_t w9,
                                         input word_t w1, input word_t w0);
        return small_sigma1(w14) + w9 + small_sigma0(w1) + w0;
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round. Word 0 of the state vector is a, word 7 is h.
module sha256_round
    import sha256_pkg::*;
(
    input  logic [7:0][31:0] st_in,
    input  logic [31:0]      w,
    input  logic [31:0]      k,
    output logic [7:0][31:0] st_out
);

    word_t t1, t2;

    always_comb begin
        t1 = st_in[7] + big_sigma1(st_in[4]) + ch(st_in[4], st_in[5], st_in[6]) + k + w;
        t2 = big_sigma0(st_in[0]) + maj(st_in[0], st_in[1], st_in[2]);
        st_out    = {st_in[6:0], t1 + t2};
        st_out[4] = st_in[3] + t1;
    end

endmodule

// File: rtl/sha256_nonce_core.sv
// Single-block SHA-256 compression from a midstate with nonce injection,
// ROUNDS_PER_CYCLE rounds per clock. SHA256_NONCE_CORE_DOUBLE_HASH_EN adds a second SHA256d pass.
module sha256_nonce_core
    import sha256_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int NONCE_IDX        = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0][31:0]  midstate,
    input  logic [15:0][31:0] block,
    input  logic [31:0]       nonce,
    output logic              busy,
    output logic              done,
    output logic [7:0][31:0]  digest
);

    localparam int R = ROUNDS_PER_CYCLE;

    state_t            state, state_nxt;
    logic [6:0]        rnd, rnd_nxt;
    logic [7:0][31:0]  hsave, work, sum;
    logic [15:0][31:0] w;
    logic [R:0][7:0][31:0]  st_chain;
    logic [R:0][15:0][31:0] w_chain;
`ifdef SHA256_NONCE_CORE_DOUBLE_HASH_EN
    logic              second;
`endif

    assign rnd_nxt     = rnd + 7'(R);
    assign st_chain[0] = work;
    assign w_chain[0]  = w;

    // Round j consumes window word 0 after j shifts, so schedule words chain in-cycle.
    for (genvar j = 0; j < R; j++) begin : g_rnd
        sha256_round u_round (
            .st_in  (st_chain[j]),
            .w      (w_chain[j][0]),
            .k      (K[rnd[5:0] + 6'(j)]),
            .st_out (st_chain[j+1])
        );
        assign w_chain[j+1] = {sched_word(w_chain[j][14], w_chain[j][9],
                                          w_chain[j][1], w_chain[j][0]),
                               w_chain[j][15:1]};
    end

    for (genvar i = 0; i < 8; i++) begin : g_sum
        assign sum[i] = hsave[i] + work[i];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = COMPUTE;
            COMPUTE: if (rnd_nxt == 7'd64) state_nxt = FINAL;
`ifdef SHA256_NONCE_CORE_DOUBLE_HASH_EN
            FINAL:   state_nxt = second ? IDLE : COMPUTE;
`else
            FINAL:   state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            digest <= '0;
            rnd    <= '0;
            hsave  <= '0;
            work   <= '0;
            w      <= '0;
`ifdef SHA256_NONCE_CORE_DOUBLE_HASH_EN
            second <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    hsave        <= midstate;
                    work         <= midstate;
                    w            <= block;
                    w[NONCE_IDX] <= nonce;
                    rnd          <= '0;
                    busy         <= 1'b1;
`ifdef SHA256_NONCE_CORE_DOUBLE_HASH_EN
                    second       <= 1'b0;
`endif
                end
                COMPUTE: begin
                    work <= st_chain[R];
                    w    <= w_chain[R];
                    rnd  <= rnd_nxt;
                end
                FINAL: begin
`ifdef SHA256_NONCE_CORE_DOUBLE_HASH_EN
                    if (!second) begin
                        // Second pass hashes the 256-bit first digest as one padded block.
                        second <= 1'b1;
                        hsave  <= IV;
                        work   <= IV;
                        w      <= {32'h00000100, 192'h0, 32'h80000000, sum};
                        rnd    <= '0;
                    end else begin
                        second <= 1'b0;
                        digest <= sum;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                    end
`else
                    digest <= sum;
                    done   <= 1'b1;
                    busy   <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_nonce_core.sv
// Self-checking bench: R=1/NONCE_IDX=0 and R=4/NONCE_IDX=3 lanes against a textbook SHA-256 model.
module tb_sha256_nonce_core;
    import sha256_pkg::*;

`ifdef SHA256_NONCE_CORE_DOUBLE_HASH_EN
    localparam bit DH = 1'b1;
`else
    localparam bit DH = 1'b0;
`endif
    localparam int LAT1 = DH ? 130 : 65;
    localparam int LAT4 = DH ? 34 : 17;

    localparam logic [7:0][31:0] ABC_S = {
        32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
        32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf};
    localparam logic [7:0][31:0] ABC_D = {
        32'h3e6c6358, 32'hd5128cc0, 32'h05daed5a, 32'h5b2d606d,
        32'h8d2da7cc, 32'h519ba6f6, 32'h2dd3729b, 32'h4f8b42c2};

    logic clk = 1'b0;
    logic reset, start1, start4;
    logic [7:0][31:0]  midstate;
    logic [15:0][31:0] block;
    logic [31:0]       nonce;
    logic busy1, done1, busy4, done4;
    logic [7:0][31:0]  digest1, digest4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sha256_nonce_core #(.ROUNDS_PER_CYCLE(1), .NONCE_IDX(0)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .midstate(midstate), .block(block),
        .nonce(nonce), .busy(busy1), .done(done1), .digest(digest1));

    sha256_nonce_core #(.ROUNDS_PER_CYCLE(4), .NONCE_IDX(3)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .midstate(midstate), .block(block),
        .nonce(nonce), .busy(busy4), .done(done4), .digest(digest4));

    // ---------------- reference model ----------------
    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [7:0][31:0] m_compress(input logic [7:0][31:0] hin,
                                                    input logic [15:0][31:0] blk);
        logic [31:0] wx [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        logic [7:0][31:0] r;
        for (int t = 0; t < 16; t++) wx[t] = blk[t];
        for (int t = 16; t < 64; t++)
            wx[t] = (ror(wx[t-2], 17) ^ ror(wx[t-2], 19) ^ (wx[t-2] >> 10)) + wx[t-7]
                  + (ror(wx[t-15], 7) ^ ror(wx[t-15], 18) ^ (wx[t-15] >> 3)) + wx[t-16];
        a = hin[0]; b = hin[1]; c = hin[2]; d = hin[3];
        e = hin[4]; f = hin[5]; g = hin[6]; h = hin[7];
        for (int t = 0; t < 64; t++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + wx[t];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        r[0] = hin[0] + a; r[1] = hin[1] + b; r[2] = hin[2] + c; r[3] = hin[3] + d;
        r[4] = hin[4] + e; r[5] = hin[5] + f; r[6] = hin[6] + g; r[7] = hin[7] + h;
        return r;
    endfunction

    function automatic logic [7:0][31:0] m_hash(input logic [7:0][31:0] ms,
                                                input logic [15:0][31:0] blk,
                                                input logic [31:0] nc, input int idx);
        logic [15:0][31:0] b = blk;
        logic [7:0][31:0]  dg;
        b[idx] = nc;
        dg = m_compress(ms, b);
        if (DH) dg = m_compress(IV, {32'h00000100, 192'h0, 32'h80000000, dg});
        return dg;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic rand_inputs();
        for (int i = 0; i < 8; i++)  midstate[i] = $urandom;
        for (int i = 0; i < 16; i++) block[i] = $urandom;
        nonce = $urandom;
    endtask

    task automatic abc_inputs();
        midstate  = IV;
        block     = '0;
        block[15] = 32'h00000018;
    endtask

    // Pulse start for one edge, then count edges until done is seen (bounded).
    task automatic run_op(input bit use4, output int edges);
        edges = 0;
        if (use4) start4 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start4 = 1'b0;
        while (edges < 400) begin
            @(posedge clk); #1;
            edges++;
            if ((use4 ? done4 : done1) === 1'b1) break;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks += 6;
        if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy1: got %b want 0", busy1); end
        if (done1 !== 1'b0) begin n_fail++; $display("FAIL reset_done1: got %b want 0", done1); end
        if (digest1 !== '0) begin n_fail++; $display("FAIL reset_digest1: got %h want 0", digest1); end
        if (busy4 !== 1'b0) begin n_fail++; $display("FAIL reset_busy4: got %b want 0", busy4); end
        if (done4 !== 1'b0) begin n_fail++; $display("FAIL reset_done4: got %b want 0", done4); end
        if (digest4 !== '0) begin n_fail++; $display("FAIL reset_digest4: got %h want 0", digest4); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_abc_r1();
        int e;
        logic [7:0][31:0] exp_d;
        abc_inputs();
        block[0] = 32'h12345678;
        nonce    = 32'h61626380;
        exp_d    = DH ? ABC_D : ABC_S;
        run_op(1'b0, e);
        n_checks += 4;
        if (e != LAT1) begin n_fail++; $display("FAIL abc_r1_latency: got %0d want %0d", e, LAT1); end
        if (digest1 !== exp_d) begin n_fail++; $display("FAIL abc_r1_digest: got %h want %h", digest1, exp_d); end
        if (busy1 !== 1'b0) begin n_fail++; $display("FAIL abc_r1_busy_at_done: got %b want 0", busy1); end
        if (digest1 !== m_hash(IV, block, nonce, 0)) begin n_fail++; $display("FAIL abc_r1_model: got %h", digest1); end
        @(posedge clk); #1;
        n_checks += 2;
        if (done1 !== 1'b0) begin n_fail++; $display("FAIL abc_r1_done_pulse: got %b want 0", done1); end
        if (digest1 !== exp_d) begin n_fail++; $display("FAIL abc_r1_hold: got %h want %h", digest1, exp_d); end
    endtask

    task automatic test_abc_r4();
        int e;
        logic [7:0][31:0] exp_d;
        abc_inputs();
        block[0] = 32'h61626380;
        block[3] = 32'hdeadbeef;
        nonce    = 32'h0;
        exp_d    = DH ? ABC_D : ABC_S;
        run_op(1'b1, e);
        n_checks += 2;
        if (e != LAT4) begin n_fail++; $display("FAIL abc_r4_latency: got %0d want %0d", e, LAT4); end
        if (digest4 !== exp_d) begin n_fail++; $display("FAIL abc_r4_digest: got %h want %h", digest4, exp_d); end
    endtask

    task automatic test_random();
        int e;
        logic [7:0][31:0] exp_d;
        for (int it = 0; it < 6; it++) begin
            rand_inputs();
            exp_d = m_hash(midstate, block, nonce, it[0] ? 3 : 0);
            run_op(it[0], e);
            n_checks += 2;
            if (e != (it[0] ? LAT4 : LAT1)) begin
                n_fail++; $display("FAIL random_latency[%0d]: got %0d", it, e);
            end
            if ((it[0] ? digest4 : digest1) !== exp_d) begin
                n_fail++;
                $display("FAIL random_digest[%0d]: got %h want %h", it, it[0] ? digest4 : digest1, exp_d);
            end
        end
    endtask

    task automatic test_nonce_override();
        int e;
        logic [15:0][31:0] ref_blk;
        logic [7:0][31:0]  exp_d;
        rand_inputs();
        block[3] = 32'hffffffff;
        nonce    = 32'h0;
        ref_blk    = block;
        ref_blk[3] = 32'h0;
        exp_d = DH ? m_compress(IV, {32'h00000100, 192'h0, 32'h80000000, m_compress(midstate, ref_blk)})
                   : m_compress(midstate, ref_blk);
        run_op(1'b1, e);
        n_checks += 2;
        if (e != LAT4) begin n_fail++; $display("FAIL override_latency: got %0d want %0d", e, LAT4); end
        if (digest4 !== exp_d) begin n_fail++; $display("FAIL override_digest: got %h want %h", digest4, exp_d); end
    endtask

    task automatic test_back_to_back();
        int e;
        logic [7:0][31:0] exp_a, exp_b;
        rand_inputs();
        exp_a  = m_hash(midstate, block, nonce, 0);
        start1 = 1'b1;
        @(posedge clk); #1;
        e = 0;
        // start held and inputs scrambled every cycle while busy
        while (e < 400) begin
            rand_inputs();
            start1 = 1'b1;
            @(posedge clk); #1;
            e++;
            if (done1 === 1'b1) break;
        end
        n_checks += 2;
        if (e != LAT1) begin n_fail++; $display("FAIL spam_latency: got %0d want %0d", e, LAT1); end
        if (digest1 !== exp_a) begin n_fail++; $display("FAIL spam_digest: got %h want %h", digest1, exp_a); end
        rand_inputs();
        exp_b = m_hash(midstate, block, nonce, 0);
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        n_checks += 2;
        if (done1 !== 1'b0) begin n_fail++; $display("FAIL b2b_done_drop: got %b want 0", done1); end
        if (busy1 !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b want 1", busy1); end
        e = 1;
        while (e < 400 && done1 !== 1'b1) begin
            @(posedge clk); #1;
            if (done1 !== 1'b1) e++;
        end
        n_checks += 2;
        if (e != LAT1) begin n_fail++; $display("FAIL b2b_latency: got %0d want %0d", e, LAT1); end
        if (digest1 !== exp_b) begin n_fail++; $display("FAIL b2b_digest: got %h want %h", digest1, exp_b); end
    endtask

    task automatic test_reset_mid();
        int e;
        int pulses = 0;
        logic [7:0][31:0] exp_d;
        abc_inputs();
        block[0] = 32'h0;
        nonce    = 32'h61626380;
        exp_d    = DH ? ABC_D : ABC_S;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (32) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        n_checks += 3;
        if (busy1 !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", busy1); end
        if (done1 !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %b want 0", done1); end
        if (digest1 !== '0) begin n_fail++; $display("FAIL midreset_digest: got %h want 0", digest1); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (150) begin
            @(posedge clk); #1;
            if (done1 === 1'b1) pulses++;
        end
        n_checks += 1;
        if (pulses != 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d pulses want 0", pulses); end
        run_op(1'b0, e);
        n_checks += 2;
        if (e != LAT1) begin n_fail++; $display("FAIL postreset_latency: got %0d want %0d", e, LAT1); end
        if (digest1 !== exp_d) begin n_fail++; $display("FAIL postreset_digest: got %h want %h", digest1, exp_d); end
    endtask

    initial begin
        reset    = 1'b0;
        start1   = 1'b0;
        start4   = 1'b0;
        midstate = '0;
        block    = '0;
        nonce    = '0;
        #2;
        test_reset();
        test_abc_r1();
        test_abc_r4();
        test_random();
        test_nonce_override();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sha256_nonce_core.md
Name: sha256_nonce_core

Overview:
- Parametrised successor to the phase-2 single-nonce compression block of the bitcoin_hash design.
- Compresses one 512-bit block from a supplied midstate, with the nonce injected at a configurable word. Computes ROUNDS_PER_CYCLE rounds per clock and uses a rolling 16-word message schedule.
- Has a start/busy/done handshake and a registered digest.
- A miner top instantiates N copies, one per nonce lane.

Parameters:
- ROUNDS_PER_CYCLE, 1, SHA rounds per clock; legal values 1, 2, 4, 8 (must divide 64).
- NONCE_IDX, 3, message word index (0..15) replaced by the nonce input.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-high.
- start  in  1  request; sampled only in IDLE.
- midstate[8]  in  32 each  chaining value, a..h initial.
- block[16]  in  32 each  message words; word NONCE_IDX is ignored.
- nonce  in  32  value substituted into word NONCE_IDX.
- busy  out  1  high from the edge after start acceptance until the FINAL edge.
- done  out  1  one-cycle pulse; digest valid.
- digest[8]  out  32 each  final hash words H0..H7.

Behaviour:
- Reset values: busy=0, done=0, digest all 0, state IDLE, round counter 0, working and schedule registers 0.
- States: IDLE, COMPUTE, FINAL.
- IDLE + start, edge E0:
  - Latch midstate into Hsave and a..h.
  - Latch block into W[0..15], with W[NONCE_IDX]=nonce.
  - rnd=0; go to COMPUTE; busy=1.
- COMPUTE, per edge:
  - Apply ROUNDS_PER_CYCLE chained rounds using W[0..R-1] and K[rnd..rnd+R-1].
  - Shift the schedule window by R; each new word is s1(W[14])+W[9]+s0(W[1])+W[0], evaluated sequentially within the cycle.
  - rnd += R.
  - On the edge where rnd reaches 64, go to FINAL.
- FINAL edge:
  - digest[i] = Hsave[i] + working[i], mod 2^32.
  - done=1 for exactly one cycle; busy=0; go to IDLE.
- Latency: done is high in the cycle following edge E0 + 64/R + 1. R=1 gives 65 edges; R=4 gives 17.
- start while busy: ignored, with no effect on the operation in progress.
- start in the same cycle done is high: accepted (state is already IDLE); done still drops next cycle.
- Inputs are not sampled after E0; they may change freely while busy.
- digest holds its value until the next FINAL edge or reset.
- reset mid-operation: immediate abort to the reset values; no done pulse.
- Arithmetic: all additions 32-bit, wrap-around, no carries kept. Rotations are by constant amounts.

Optional Feature:
- Macro: SHA256_NONCE_CORE_DOUBLE_HASH_EN.
- Defined:
  - After the first FINAL, a second pass runs with midstate = standard IV (6a09e667 ... 5be0cd19).
  - Second-pass block = first digest[0..7], then 0x80000000, then 6 zero words, then 0x00000100.
  - busy stays high between passes; done pulses only after the second FINAL.
  - Latency is 2*(64/R + 1) edges; digest is SHA256d.
- Undefined: single pass as described above; no extra logic.

Decomposition:
- Package sha256_pkg, shared by the miner top:
  - word_t (logic [31:0]) typedef.
  - State enum typedef.
  - K[64] constant table.
  - IV[8] constant.
  - Functions: rightrotate, big/small sigma, ch, maj, schedule-word function.
- One combinational sub-module, sha256_round: one round (a..h, w, k in; a..h out). It is instantiated ROUNDS_PER_CYCLE times in a generate chain.

Test Plan:
- Single "abc" block, R=1:
  - Stimulus: NONCE_IDX=0, nonce=0x61626380, midstate=IV, block[1..14]=0, block[15]=0x00000018.
  - Response: done 65 edges after start; digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Same "abc" stimulus with R=4:
  - Response: identical digest, with done after 17 edges.
- DOUBLE_HASH_EN defined, "abc" stimulus, R=1:
  - Response: digest = 4f8b42c2 2dd3729b 519ba6f6 8d2da7cc 5b2d606d 05daed5a d5128cc0 3e6c6358; done after 130 edges; single done pulse.
- Pulse start every cycle during one operation:
  - Response: only one done pulse; digest matches the first request.
  - Re-assert start in the done cycle: a second op is accepted; its done arrives 65 edges later.
- Assert reset at rnd=32:
  - Response: busy=0, done never pulses, digest=0.
  - Next start after deasserting reset yields the correct "abc" digest.
- NONCE_IDX=3, block[3]=0xFFFFFFFF, nonce=0:
  - Response: digest equals the reference model with word 3 = 0, proving the block word is overridden.
